// File: rtl/conv_layer_engine.sv
// Convolution-layer compute engine: streams one pixel per enabled cycle against DSP_NO
// weight lanes, then adds bias, requantises, saturates, applies optional ReLU and strobes out.
module conv_layer_engine #(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 16,
  parameter int CHIN       = 64,
  parameter int KERNEL_DIM = 3,
  parameter int WOUT       = 64,
  parameter int FRAC_BITS  = 14,
  parameter int RELU       = 1,
  localparam int N         = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int AW        = (N > 1) ? $clog2(N) : 1,
  localparam int ACC_W     = 2 * WIDTH + AW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        layer_en_i,
  input  logic [WIDTH-1:0]            ifm_i,
  output logic [AW-1:0]               weight_addr_o,
  input  logic [DSP_NO*WIDTH-1:0]     kernels_i,
  input  logic [DSP_NO*2*WIDTH-1:0]   bias_i,
  input  logic                        ram_feedback_i,
  output logic [DSP_NO*WIDTH-1:0]     ofm_o,
  output logic                        sample_o,
  output logic                        finish_o
);

  localparam int P  = WOUT * WOUT;
  localparam int PW = $clog2(P + 1);
  localparam logic signed [ACC_W:0] QMAX = {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] QMIN = {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [AW-1:0]             k;
  logic [PW-1:0]             pix_cnt;
  logic                      fb_flag;
  logic signed [WIDTH-1:0]   pix_r;
  logic                      pix_v, pix_first, pix_last;
  logic                      acc_done, sum_v;
  logic                      last_px, done_now, accept, fire;

  // done_now is the next-state view of DONE, so a beat or result coinciding with
  // the final strobe is dropped rather than leaking into a finished layer.
  assign last_px       = sample_o && (pix_cnt == PW'(P - 1));
  assign done_now      = (state == DONE) || last_px;
  assign accept        = layer_en_i && !done_now;
  assign fire          = sum_v && !done_now;
  assign weight_addr_o = k;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      pix_cnt   <= '0;
      fb_flag   <= 1'b0;
      pix_r     <= '0;
      pix_v     <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      acc_done  <= 1'b0;
      sum_v     <= 1'b0;
      sample_o  <= 1'b0;
      finish_o  <= 1'b0;
    end else begin
      if (ram_feedback_i) fb_flag <= 1'b1;
      pix_v <= accept;
      if (accept) begin
        pix_r     <= ifm_i;
        pix_first <= (k == '0);
        pix_last  <= (k == AW'(N - 1));
        k         <= (k == AW'(N - 1)) ? '0 : k + AW'(1);
      end
      acc_done <= pix_v && pix_last;
      sum_v    <= acc_done;
      sample_o <= fire;
      if (sample_o) pix_cnt <= pix_cnt + PW'(1);
      finish_o <= done_now && !fb_flag && !ram_feedback_i;
      case (state)
        IDLE:    if (accept) state <= RUN;
        RUN:     if (last_px) state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
    logic signed [WIDTH-1:0]   ker;
    logic signed [2*WIDTH-1:0] bias;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc, acc_base;
    logic signed [ACC_W:0]     sum_r, q;
    logic [WIDTH-1:0]          sat, ofm_q;

    assign ker      = kernels_i[l*WIDTH +: WIDTH];
    assign bias     = bias_i[l*2*WIDTH +: 2*WIDTH];
    // Low 2*WIDTH bits of the product are sign-agnostic once both operands are sign-extended.
    assign prod     = $signed({{WIDTH{pix_r[WIDTH-1]}}, pix_r} * {{WIDTH{ker[WIDTH-1]}}, ker});
    assign acc_base = pix_first ? '0 : acc;
    assign q        = sum_r >>> FRAC_BITS;
    assign ofm_o[l*WIDTH +: WIDTH] = ofm_q;

    always_comb begin
      if (q > QMAX)      sat = {1'b0, {(WIDTH - 1){1'b1}}};
      else if (q < QMIN) sat = {1'b1, {(WIDTH - 1){1'b0}}};
      else               sat = q[WIDTH-1:0];
      if (RELU != 0 && q[ACC_W]) sat = '0;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        acc   <= '0;
        sum_r <= '0;
        ofm_q <= '0;
      end else begin
        if (pix_v)    acc   <= acc_base + {{AW{prod[2*WIDTH-1]}}, prod};
        if (acc_done) sum_r <= {acc[ACC_W-1], acc} + {{(ACC_W + 1 - 2*WIDTH){bias[2*WIDTH-1]}}, bias};
        if (fire)     ofm_q <= sat;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_engine.sv
// Randomised self-checking bench for conv_layer_engine: ReLU and non-ReLU instances
// share one stimulus stream and are compared against a pixel-level arithmetic model.
module tb_conv_layer_engine;
  localparam int WIDTH = 16, DSP_NO = 2, CHIN = 2, KERNEL_DIM = 1, WOUT = 2, FRAC_BITS = 14;
  localparam int N = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int P = WOUT * WOUT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst = 1'b0, layer_en_i = 1'b0, ram_feedback_i = 1'b0;
  logic [WIDTH-1:0]          ifm_i = '0;
  logic [DSP_NO*WIDTH-1:0]   kernels_i;
  logic [DSP_NO*2*WIDTH-1:0] bias_i = '0;
  logic [0:0]                addr_a, addr_b;
  logic [DSP_NO*WIDTH-1:0]   ofm_a, ofm_b;
  logic                      samp_a, samp_b, fin_a, fin_b;

  conv_layer_engine #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM),
    .WOUT(WOUT), .FRAC_BITS(FRAC_BITS), .RELU(1)) dut (
    .clk(clk), .rst(rst), .layer_en_i(layer_en_i), .ifm_i(ifm_i), .weight_addr_o(addr_a),
    .kernels_i(kernels_i), .bias_i(bias_i), .ram_feedback_i(ram_feedback_i),
    .ofm_o(ofm_a), .sample_o(samp_a), .finish_o(fin_a));

  conv_layer_engine #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM),
    .WOUT(WOUT), .FRAC_BITS(FRAC_BITS), .RELU(0)) dut_nr (
    .clk(clk), .rst(rst), .layer_en_i(layer_en_i), .ifm_i(ifm_i), .weight_addr_o(addr_b),
    .kernels_i(kernels_i), .bias_i(bias_i), .ram_feedback_i(ram_feedback_i),
    .ofm_o(ofm_b), .sample_o(samp_b), .finish_o(fin_b));

  int rom [N][DSP_NO];
  int bias_v [DSP_NO];
  int beats [$];
  int last_edge [$];
  logic [DSP_NO*WIDTH-1:0] got_a [$], got_b [$];
  int got_cyc [$];
  int cyc = 0;
  int fin_cyc = -1;
  int n_checks = 0, n_fail = 0;

  // Weight ROM with one cycle of read latency
  always @(posedge clk) begin
    logic [DSP_NO*WIDTH-1:0] w;
    int v;
    for (int l = 0; l < DSP_NO; l++) begin
      v = rom[addr_a][l];
      w[l*WIDTH +: WIDTH] = v[WIDTH-1:0];
    end
    kernels_i <= w;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (samp_a) begin
      got_a.push_back(ofm_a);
      got_cyc.push_back(cyc);
    end
    if (samp_b) got_b.push_back(ofm_b);
    if (fin_a && fin_cyc < 0) fin_cyc = cyc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_px(input int p, input int lane, input bit relu);
    longint s;
    s = 0;
    for (int b = 0; b < N; b++) s += longint'(beats[p*N+b]) * longint'(rom[b][lane]);
    s += longint'(bias_v[lane]);
    s = s >>> FRAC_BITS;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [DSP_NO*WIDTH-1:0] ref_word(input int p, input bit relu);
    logic [DSP_NO*WIDTH-1:0] w;
    for (int l = 0; l < DSP_NO; l++) w[l*WIDTH +: WIDTH] = ref_px(p, l, relu);
    return w;
  endfunction

  task automatic set_params(input int ker, input int b0, input int b1);
    for (int b = 0; b < N; b++)
      for (int l = 0; l < DSP_NO; l++) rom[b][l] = ker;
    bias_v[0] = b0;
    bias_v[1] = b1;
  endtask

  task automatic apply_bias();
    for (int l = 0; l < DSP_NO; l++) bias_i[l*2*WIDTH +: 2*WIDTH] = bias_v[l];
  endtask

  task automatic do_reset(input int n, input bit chk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chk && i > 0) begin
        check("rst ofm", ofm_a, '0);
        check("rst ofm_nr", ofm_b, '0);
        check("rst sample", samp_a, 0);
        check("rst finish", fin_a, 0);
        check("rst addr", addr_a, 0);
      end
      rst = 1'b0;
      layer_en_i = 1'($urandom_range(0, 1));
      ifm_i = WIDTH'($urandom);
      ram_feedback_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b1;
    layer_en_i = 1'b0;
    ram_feedback_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    layer_en_i = 1'b0;
    ifm_i = WIDTH'($urandom);
  endtask

  // mode 0: continuous, 1: alternate enable, 2: random stalls
  task automatic run_layer(input string name, input int mode, input bit fb_before);
    int t, v, npix;
    npix = beats.size() / N;
    got_a.delete(); got_b.delete(); got_cyc.delete(); last_edge.delete();
    fin_cyc = -1;
    apply_bias();
    if (fb_before) begin
      @(negedge clk); ram_feedback_i = 1'b1;
      @(negedge clk); ram_feedback_i = 1'b0;
    end
    for (int b = 0; b < beats.size(); b++) begin
      if (mode == 1 && b > 0) idle_cycle();
      if (mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      @(negedge clk);
      check($sformatf("%s addr b%0d", name, b), addr_a, b % N);
      v = beats[b];
      layer_en_i = 1'b1;
      ifm_i = v[WIDTH-1:0];
      if (b % N == N - 1) last_edge.push_back(cyc + 1);
    end
    idle_cycle();
    t = 0;
    while (got_a.size() < npix && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({name, " nsamp"}, got_a.size(), npix);
    check({name, " nsamp_nr"}, got_b.size(), npix);
    for (int p = 0; p < npix && p < got_a.size() && p < got_b.size(); p++) begin
      check($sformatf("%s px%0d relu", name, p), got_a[p], ref_word(p, 1'b1));
      check($sformatf("%s px%0d norelu", name, p), got_b[p], ref_word(p, 1'b0));
      check($sformatf("%s px%0d latency", name, p), got_cyc[p], last_edge[p] + 3);
    end
    if (npix == P && !fb_before) check({name, " finish"}, fin_cyc, last_edge[P-1] + 4);
    else check({name, " no finish"}, fin_cyc, -1);
  endtask

  initial begin
    set_params(16384, 0, 0);
    do_reset(3, 1'b0);

    // Basic MAC, continuous stream
    set_params(16384, 0, 1 << 14);
    beats.delete();
    repeat (P * N) beats.push_back(8192);
    run_layer("basic", 0, 1'b0);
    check("basic px0 const", got_a.size() > 0 ? got_a[0] : 'x, 32'h4001_4000);

    // Beats after completion are ignored; feedback clears finish
    repeat (3) begin
      @(negedge clk);
      layer_en_i = 1'b1;
      ifm_i = WIDTH'($urandom);
    end
    idle_cycle();
    repeat (4) @(negedge clk);
    check("done addr frozen", addr_a, 0);
    check("done no sample", got_a.size(), P);
    check("done finish held", fin_a, 1);
    @(negedge clk); ram_feedback_i = 1'b1;
    @(negedge clk); ram_feedback_i = 1'b0;
    repeat (3) @(negedge clk);
    check("feedback finish low", fin_a, 0);
    check("feedback finish low nr", fin_b, 0);

    // Reset from a busy DONE state with random inputs, then a reset mid-pixel
    do_reset(4, 1'b1);
    @(negedge clk); layer_en_i = 1'b1; ifm_i = 16'h7FFF;
    idle_cycle();
    do_reset(2, 1'b0);
    got_a.delete();
    run_layer("stall", 1, 1'b0);
    check("stall px1 const", got_a.size() > 1 ? got_a[1] : 'x, 32'h4001_4000);

    // Negative result: ReLU clamps, non-ReLU keeps sign
    do_reset(2, 1'b0);
    set_params(-16384, 0, 0);
    run_layer("sign", 0, 1'b0);
    check("sign relu const", got_a.size() > 0 ? got_a[0] : 'x, 32'h0000_0000);
    check("sign norelu const", got_b.size() > 0 ? got_b[0] : 'x, 32'hC000_C000);

    // Saturation at both rails
    do_reset(2, 1'b0);
    set_params(32767, 0, 0);
    beats.delete();
    repeat (N * 2) beats.push_back(32767);
    repeat (N * 2) beats.push_back(-32768);
    run_layer("sat", 0, 1'b0);
    check("sat pos const", got_a.size() > 0 ? got_a[0] : 'x, 32'h7FFF_7FFF);
    check("sat neg const", got_b.size() > 3 ? got_b[3] : 'x, 32'h8000_8000);

    // Random layers with random stalls and early feedback
    for (int r = 0; r < 8; r++) begin
      do_reset(2, 1'b0);
      for (int b = 0; b < N; b++)
        for (int l = 0; l < DSP_NO; l++) rom[b][l] = int'($urandom_range(0, 65535)) - 32768;
      for (int l = 0; l < DSP_NO; l++) bias_v[l] = int'($urandom) >>> $urandom_range(0, 18);
      beats.delete();
      repeat (P * N) beats.push_back(int'($urandom_range(0, 65535)) - 32768);
      run_layer($sformatf("rand%0d", r), int'($urandom_range(0, 2)), r % 3 == 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/conv_layer_engine.md
# conv_layer_engine

Parametrised convolution-layer compute engine for the SqueezeNet accelerator: streams one input pixel per enabled cycle, drives the layer's weight-ROM address, and accumulates DSP_NO output channels in parallel. Once per output pixel it adds bias, requantises with saturation, applies optional ReLU, and strobes the result to the output RAM. It is the successor of the per-layer squeeze engines: one RTL block for all squeeze/expand layers, with synchronous reset, stall support, guard-bit accumulation and saturating output.

## Interface
- WIDTH, 16: pixel/weight/output width, signed two's complement
- DSP_NO, 16: parallel output channels (MAC lanes)
- CHIN, 64: input channels
- KERNEL_DIM, 3: kernel side; beats per output pixel N = KERNEL_DIM**2*CHIN
- WOUT, 64: output side; pixels per layer P = WOUT**2
- FRAC_BITS, 14: fractional bits in the product; requantisation right-shift
- RELU, 1: 1 = clamp negative outputs to 0
- ACC_W, 2*WIDTH+$clog2(N): accumulator width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-low
- layer_en_i  in  1  ifm_i carries a valid beat this cycle
- ifm_i  in  WIDTH  input pixel
- weight_addr_o  out  $clog2(N)  weight-ROM address of the current beat
- kernels_i  in  DSP_NO*WIDTH  ROM data, lane k at [k*WIDTH +: WIDTH], 1-cycle ROM latency
- bias_i  in  DSP_NO*2*WIDTH  per-lane bias, same Q format as product, static
- ram_feedback_i  in  1  output RAM acknowledges layer completion
- ofm_o  out  DSP_NO*WIDTH  output pixel, lane-packed
- sample_o  out  1  one-cycle strobe: ofm_o holds a new pixel
- finish_o  out  1  layer done, not yet acknowledged

## Operation
- FSM: IDLE -> RUN on first accepted beat; RUN -> DONE when the P-th sample_o is issued; DONE held until rst low.
- Beat accepted when layer_en_i=1 and state != DONE. Beats in DONE are ignored: no address advance, no accumulation.
- Beat counter k (0..N-1) advances per accepted beat and wraps to 0 after N-1. weight_addr_o = k (registered counter value), so the ROM returns the weights for beat k one cycle later.
- ifm_i registered once to align with kernels_i; a valid bit travels with it.
- Accumulate stage, per lane: acc <= (first beat ? 0 : acc) + sext(pix*ker). The first-beat flag replaces a clear pulse, so there is no dead cycle between pixels.
- After beat N-1 is accumulated, output stage per lane: s = acc + sext(bias); q = s >>> FRAC_BITS (arithmetic); saturate q to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; if RELU and q<0 then 0. Register into ofm_o and pulse sample_o.
- Pixel counter counts sample_o pulses; reaching P enters DONE.
- ram_feedback_i sets a sticky flag, cleared only by reset. finish_o = (state==DONE) && !flag.

## Timing
- Reset (rst=0 at an edge): state IDLE; k, pixel count, acc, ofm_o = 0; sample_o=0; finish_o=0; weight_addr_o=0; feedback flag cleared. Reset mid-pixel discards the partial sum and produces no sample.
- Latency: last beat of a pixel accepted at edge e; sample_o high and ofm_o valid in the cycle after edge e+3. Back-to-back pixels with no stalls give sample_o every N cycles.
- Stall: layer_en_i=0 freezes k, weight_addr_o and the accumulators. Pipeline bubbles never accumulate. Results are bit-identical to an unstalled stream.
- ofm_o holds its value between strobes.
- finish_o rises the cycle after the final sample_o.
- ram_feedback_i asserted before DONE: flag still set, so finish_o never rises for this layer. ram_feedback_i in the same cycle DONE is entered: finish_o stays 0.
- Pixel count reaching P and a layer_en_i beat in the same cycle: the beat is dropped.

## Test plan
Test parameters: WIDTH=16, DSP_NO=2, CHIN=2, KERNEL_DIM=1 (N=2), WOUT=2 (P=4), FRAC_BITS=14.
- Reset: hold rst=0 with random inputs -> all outputs 0, weight_addr_o=0. Assert rst mid-pixel -> no sample_o, next pixel correct.
- Basic MAC: ifm=8192, kernels lane0=lane1=16384, bias0=0, bias1=1<<14, continuous enable -> weight_addr_o 0,1,0,1; ofm lane0=16384, lane1=16385; sample_o every 2 cycles, first 3 cycles after the second beat's edge.
- Sign/ReLU: kernels=-16384 -> RELU=1 gives 0x0000; RELU=0 gives 0xC000.
- Saturation: ifm=32767, kernel=32767 -> 0x7FFF. ifm=-32768, kernel=32767 with RELU=0 -> 0x8000.
- Stalls: repeat the Basic MAC scenario with layer_en_i toggling 1/0 -> identical ofm_o values, strobes spaced 4 cycles apart.
- Finish: 4 pixels -> finish_o=1 the cycle after the 4th sample. Extra beats -> no sample_o, address frozen. Pulse ram_feedback_i -> finish_o=0 permanently until reset.
